// File: rtl/sdio_slotmux.sv
// Multi-slot SDIO front-end mux: routes one controller to the active card slot,
// switches slots only after a quiet bus period, and debounces card-detect inputs.
module sdio_slotmux #(
  parameter  int NSLOT       = 2,
  parameter  int IDLE_CYCLES = 8,
  parameter  int DEBOUNCE    = 65536,
  localparam int LGS         = (NSLOT > 2) ? $clog2(NSLOT) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_sel_stb,
  input  logic [LGS-1:0]        i_sel,
  output logic                  o_sel_busy,
  output logic [LGS-1:0]        o_active,
  input  logic [7:0]            i_sdclk,
  input  logic                  i_cmd_en,
  input  logic [1:0]            i_cmd_data,
  input  logic                  i_data_en,
  input  logic [31:0]           i_tx_data,
  output logic [8*NSLOT-1:0]    o_sdclk,
  output logic [NSLOT-1:0]      o_cmd_en,
  output logic [2*NSLOT-1:0]    o_cmd_data,
  output logic [NSLOT-1:0]      o_data_en,
  output logic [32*NSLOT-1:0]   o_tx_data,
  input  logic [2*NSLOT-1:0]    i_rx_strb,
  input  logic [16*NSLOT-1:0]   i_rx_data,
  input  logic [NSLOT-1:0]      i_card_busy,
  output logic [1:0]            o_rx_strb,
  output logic [15:0]           o_rx_data,
  output logic                  o_card_busy,
  input  logic [NSLOT-1:0]      i_card_detect,
  output logic [NSLOT-1:0]      o_card_present,
  output logic                  o_int
);
  localparam int DBW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_QUIET, ST_SWITCH} state_t;

  state_t          r_state, w_next;
  logic [LGS-1:0]  r_active, r_pending;
  logic [7:0]      r_quiet_cnt;
  logic            w_req_ok, w_quiet, w_quiet_done, w_switch;
  logic [31:0]     w_act_idx;

  logic [NSLOT-1:0] r_sync1, r_sync2, r_present, r_present_q;
  logic [DBW-1:0]   r_db_cnt [NSLOT];
  logic             r_int;

  assign w_req_ok     = i_sel_stb && (32'(i_sel) < 32'(NSLOT)) && (i_sel != r_active);
  assign w_quiet      = !i_cmd_en && !i_data_en && !i_card_busy[r_active];
  assign w_quiet_done = w_quiet && (r_quiet_cnt == 8'(IDLE_CYCLES - 1));
  assign w_act_idx    = 32'(r_active);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:       if (w_req_ok) w_next = ST_WAIT_QUIET;
      ST_WAIT_QUIET: if (w_quiet_done) w_next = ST_SWITCH;
      ST_SWITCH:     w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_sel_busy = (r_state != ST_IDLE);
    w_switch   = (r_state == ST_SWITCH);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_active    <= '0;
      r_pending   <= '0;
      r_quiet_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_quiet_cnt <= '0;
          if (w_req_ok) r_pending <= i_sel;
        end
        ST_WAIT_QUIET: r_quiet_cnt <= w_quiet ? r_quiet_cnt + 8'd1 : '0;
        ST_SWITCH: begin
          r_active    <= r_pending;
          r_quiet_cnt <= '0;
        end
        default: r_quiet_cnt <= '0;
      endcase
    end
  end

  // The SWITCH cycle parks every slot, including the outgoing one, in its idle pattern.
  always_comb begin
    o_sdclk    = '0;
    o_cmd_en   = '0;
    o_cmd_data = '1;
    o_data_en  = '0;
    o_tx_data  = '1;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      if (!w_switch && r_active == LGS'(k)) begin
        o_sdclk[8*k +: 8]     = i_sdclk;
        o_cmd_en[k]           = i_cmd_en;
        o_cmd_data[2*k +: 2]  = i_cmd_data;
        o_data_en[k]          = i_data_en;
        o_tx_data[32*k +: 32] = i_tx_data;
      end
    end
    o_rx_strb   = '0;
    o_rx_data   = '0;
    o_card_busy = 1'b0;
    if (!w_switch) begin
      o_rx_strb   = i_rx_strb[2*w_act_idx +: 2];
      o_rx_data   = i_rx_data[16*w_act_idx +: 16];
      o_card_busy = i_card_busy[r_active];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_present   <= '0;
      r_present_q <= '0;
      r_int       <= 1'b0;
      for (int unsigned k = 0; k < NSLOT; k++) r_db_cnt[k] <= '0;
    end else begin
      r_sync1     <= i_card_detect;
      r_sync2     <= r_sync1;
      r_present_q <= r_present;
      r_int       <= |(r_present ^ r_present_q);
      for (int unsigned k = 0; k < NSLOT; k++) begin
        if (r_sync2[k] != r_present[k]) begin
          if (r_db_cnt[k] == DBW'(DEBOUNCE - 1)) begin
            r_present[k] <= r_sync2[k];
            r_db_cnt[k]  <= '0;
          end else begin
            r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
          end
        end else begin
          r_db_cnt[k] <= '0;
        end
      end
    end
  end

  assign o_active       = r_active;
  assign o_card_present = r_present;
  assign o_int          = r_int;

endmodule

// File: tb/tb_sdio_slotmux.sv
// Bench for sdio_slotmux: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of slot switching and debounce.
module tb_sdio_slotmux;
  localparam int NS = 4;
  localparam int IC = 8;
  localparam int DB = 16;
  localparam int LG = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                sel_stb;
  logic [LG-1:0]       sel;
  logic [7:0]          sdclk;
  logic                cmd_en;
  logic [1:0]          cmd_data;
  logic                data_en;
  logic [31:0]         tx_data;
  logic [2*NS-1:0]     rx_strb;
  logic [16*NS-1:0]    rx_data;
  logic [NS-1:0]       card_busy;
  logic [NS-1:0]       card_detect;

  logic                sel_busy;
  logic [LG-1:0]       active;
  logic [8*NS-1:0]     o_sdclk;
  logic [NS-1:0]       o_cmd_en;
  logic [2*NS-1:0]     o_cmd_data;
  logic [NS-1:0]       o_data_en;
  logic [32*NS-1:0]    o_tx_data;
  logic [1:0]          o_rx_strb;
  logic [15:0]         o_rx_data;
  logic                o_card_busy;
  logic [NS-1:0]       o_card_present;
  logic                o_int;

  // second instance with a non-power-of-two slot count for out-of-range requests
  logic                s3_stb;
  logic [1:0]          s3_sel;
  logic                s3_busy;
  logic [1:0]          s3_active;
  logic [23:0]         s3_sdclk;
  logic [2:0]          s3_cmd_en, s3_data_en, s3_present;
  logic [5:0]          s3_cmd_data;
  logic [95:0]         s3_tx_data;
  logic [1:0]          s3_rx_strb;
  logic [15:0]         s3_rx_data;
  logic                s3_card_busy, s3_int;

  sdio_slotmux #(.NSLOT(NS), .IDLE_CYCLES(IC), .DEBOUNCE(DB)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_sel_stb(sel_stb), .i_sel(sel),
    .o_sel_busy(sel_busy), .o_active(active),
    .i_sdclk(sdclk), .i_cmd_en(cmd_en), .i_cmd_data(cmd_data),
    .i_data_en(data_en), .i_tx_data(tx_data),
    .o_sdclk(o_sdclk), .o_cmd_en(o_cmd_en), .o_cmd_data(o_cmd_data),
    .o_data_en(o_data_en), .o_tx_data(o_tx_data),
    .i_rx_strb(rx_strb), .i_rx_data(rx_data), .i_card_busy(card_busy),
    .o_rx_strb(o_rx_strb), .o_rx_data(o_rx_data), .o_card_busy(o_card_busy),
    .i_card_detect(card_detect), .o_card_present(o_card_present), .o_int(o_int)
  );

  sdio_slotmux #(.NSLOT(3), .IDLE_CYCLES(IC), .DEBOUNCE(DB)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_sel_stb(s3_stb), .i_sel(s3_sel),
    .o_sel_busy(s3_busy), .o_active(s3_active),
    .i_sdclk(sdclk), .i_cmd_en(cmd_en), .i_cmd_data(cmd_data),
    .i_data_en(data_en), .i_tx_data(tx_data),
    .o_sdclk(s3_sdclk), .o_cmd_en(s3_cmd_en), .o_cmd_data(s3_cmd_data),
    .o_data_en(s3_data_en), .o_tx_data(s3_tx_data),
    .i_rx_strb(rx_strb[5:0]), .i_rx_data(rx_data[47:0]), .i_card_busy(card_busy[2:0]),
    .o_rx_strb(s3_rx_strb), .o_rx_data(s3_rx_data), .o_card_busy(s3_card_busy),
    .i_card_detect(card_detect[2:0]), .o_card_present(s3_present), .o_int(s3_int)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 waiting for a quiet run, 2 the one switch cycle.
  int            m_phase;
  logic [LG-1:0] m_active, m_pending;
  int            m_run;
  logic [NS-1:0] m_s1, m_s2, m_pres;
  int            m_db [NS];
  logic          m_int, m_chg;
  bit            mon_en = 1'b0;
  bit            m_quiet;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_active = '0; m_pending = '0; m_run = 0;
      m_s1 = '0; m_s2 = '0; m_pres = '0; m_int = 1'b0; m_chg = 1'b0;
      for (int k = 0; k < NS; k++) m_db[k] = 0;
      mon_en = 1'b1;
    end else begin
      m_quiet = !cmd_en && !data_en && !card_busy[m_active];
      case (m_phase)
        0: if (sel_stb && int'(sel) < NS && sel != m_active) begin
             m_pending = sel; m_phase = 1; m_run = 0;
           end
        1: if (m_quiet) begin
             m_run++;
             if (m_run == IC) m_phase = 2;
           end else m_run = 0;
        default: begin m_active = m_pending; m_phase = 0; end
      endcase
      m_int = m_chg;
      m_chg = 1'b0;
      for (int k = 0; k < NS; k++) begin
        if (m_s2[k] != m_pres[k]) begin
          m_db[k]++;
          if (m_db[k] == DB) begin m_pres[k] = m_s2[k]; m_db[k] = 0; m_chg = 1'b1; end
        end else m_db[k] = 0;
      end
      m_s2 = m_s1;
      m_s1 = card_detect;
    end
  end

  logic [8*NS-1:0]  e_sdclk;
  logic [NS-1:0]    e_cmd_en, e_data_en;
  logic [2*NS-1:0]  e_cmd_data;
  logic [32*NS-1:0] e_tx;
  logic [1:0]       e_rx_strb;
  logic [15:0]      e_rx_data;
  logic             e_busy;

  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      chk("busy", sel_busy, m_phase != 0);
      chk("active", active, m_active);
      chk("present", o_card_present, m_pres);
      chk("int", o_int, m_int);
      e_sdclk = '0; e_cmd_en = '0; e_cmd_data = '1; e_data_en = '0; e_tx = '1;
      e_rx_strb = '0; e_rx_data = '0; e_busy = 1'b0;
      for (int k = 0; k < NS; k++) begin
        if (m_phase != 2 && int'(m_active) == k) begin
          e_sdclk[8*k +: 8] = sdclk; e_cmd_en[k] = cmd_en; e_cmd_data[2*k +: 2] = cmd_data;
          e_data_en[k] = data_en; e_tx[32*k +: 32] = tx_data;
          e_rx_strb = rx_strb[2*k +: 2]; e_rx_data = rx_data[16*k +: 16]; e_busy = card_busy[k];
        end
      end
      chk("sdclk", o_sdclk, e_sdclk);
      chk("cmd_en", o_cmd_en, e_cmd_en);
      chk("cmd_data", o_cmd_data, e_cmd_data);
      chk("data_en", o_data_en, e_data_en);
      chk("tx_data", o_tx_data, e_tx);
      chk("rx_strb", o_rx_strb, e_rx_strb);
      chk("rx_data", o_rx_data, e_rx_data);
      chk("card_busy", o_card_busy, e_busy);
    end
  end

  task automatic set_quiet();
    sel_stb = 1'b0; cmd_en = 1'b0; data_en = 1'b0; card_busy = '0; s3_stb = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic request(input logic [LG-1:0] s);
    @(negedge clk); sel = s; sel_stb = 1'b1;
    @(negedge clk); sel_stb = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (sel_busy && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) chk(tag, 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int n, pulses, n_rise;
    rst_n = 1'b1; set_quiet(); sel = '0; s3_sel = '0;
    sdclk = 8'hA5; cmd_data = 2'b01; tx_data = 32'hDEAD_BEEF;
    rx_strb = '0; rx_data = '0; card_detect = '0;

    do_reset();
    #1;
    chk("rst_busy", sel_busy, 1'b0);
    chk("rst_active", active, 2'd0);
    chk("rst_present", o_card_present, 4'h0);
    chk("rst_int", o_int, 1'b0);

    // request slot 1 while the data bus stays busy for 20 cycles
    @(negedge clk); sel = 2'd1; sel_stb = 1'b1; data_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); sel_stb = 1'b0; #1;
      chk("hold_active", active, 2'd0);
      chk("hold_busy", sel_busy, 1'b1);
    end
    @(negedge clk); data_en = 1'b0;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (sel_busy && n < 40);
    chk("quiet_latency", n, IC + 1);
    chk("switch_to1", active, 2'd1);

    // same-slot request and out-of-range request on the 3-slot instance
    @(negedge clk); sel = 2'd1; sel_stb = 1'b1; s3_sel = 2'd3; s3_stb = 1'b1;
    @(negedge clk); sel_stb = 1'b0; s3_stb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("same_busy", sel_busy, 1'b0);
      chk("same_active", active, 2'd1);
      chk("oor_busy", s3_busy, 1'b0);
      chk("oor_active", s3_active, 2'd0);
      @(negedge clk);
    end

    // quiet switch to slot 2: busy until the tenth cycle after the request
    tx_data = 32'h1234_5678;
    sel = 2'd2; sel_stb = 1'b1;
    n = 0;
    do begin @(negedge clk); sel_stb = 1'b0; #1; n++; end while (sel_busy && n < 40);
    chk("switch_latency", n, IC + 2);
    chk("switch_to2", active, 2'd2);
    chk("slot2_tx", o_tx_data[64 +: 32], 32'h1234_5678);
    chk("slot0_idle_tx", o_tx_data[0 +: 32], 32'hFFFF_FFFF);

    // card-detect glitch, then a steady insert on slot 1
    do_reset();
    pulses = 0; n_rise = 0;
    @(negedge clk); card_detect[1] = 1'b1;
    repeat (5) begin @(negedge clk); #1; pulses += int'(o_int); end
    card_detect[1] = 1'b0;
    repeat (4) begin @(negedge clk); #1; pulses += int'(o_int); end
    chk("glitch_present", o_card_present[1], 1'b0);
    card_detect[1] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk); #1;
      pulses += int'(o_int);
      if (o_card_present[1] && n_rise == 0) n_rise = i;
    end
    chk("debounce_latency", n_rise, DB + 2);
    chk("int_pulses", pulses, 1);

    // reset in the middle of a pending switch
    request(2'd2);
    wait_idle("to2_timeout");
    request(2'd3);
    repeat (2) @(negedge clk);
    #1;
    chk("midwait_busy", sel_busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rstq_busy", sel_busy, 1'b0);
    chk("rstq_active", active, 2'd0);
    chk("rstq_present", o_card_present, 4'h0);
    rst_n = 1'b1;

    // randomized traffic, model-checked every cycle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n    = ($urandom % 500 != 0);
      sdclk    = 8'($urandom);
      cmd_data = 2'($urandom);
      tx_data  = $urandom;
      rx_strb  = 8'($urandom);
      rx_data  = {$urandom, $urandom};
      cmd_en   = ($urandom % 16 == 0);
      data_en  = ($urandom % 16 == 0);
      for (int k = 0; k < NS; k++) begin
        card_busy[k]   = ($urandom % 16 == 0);
        card_detect[k] = card_detect[k] ^ ($urandom % 30 == 0);
      end
      sel_stb = ($urandom % 6 == 0);
      sel     = 2'($urandom);
    end
    set_quiet();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
